// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one simple dual-port RAM between two requesters,
// with optional post-reset zero-fill. Define RAM_ARB_STATS_EN to add per-requester grant counters.
module ram_port_arbiter #(
  parameter int unsigned DSIZE          = 8,
  parameter int unsigned ASIZE          = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [ASIZE-1:0] req0_addr,
  input  logic [DSIZE-1:0] req0_wdata,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [ASIZE-1:0] req1_addr,
  input  logic [DSIZE-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [DSIZE-1:0] rsp0_rdata,
  output logic             rsp1_valid,
  output logic [DSIZE-1:0] rsp1_rdata,
  output logic [ASIZE-1:0] ram_addra,
  output logic [DSIZE-1:0] ram_dinc,
  output logic             ram_wec,
  output logic             ram_ena,
  input  logic [DSIZE-1:0] ram_douta,
  output logic             busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]      grant0_cnt,
  output logic [15:0]      grant1_cnt
`endif
);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ASIZE-1:0] clr_addr_q, clr_addr_d;
  logic             last_grant_q, last_grant_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q, rd_owner_d;

  logic             clearing, running, grant1, xfer;
  logic             sel_we;
  logic [ASIZE-1:0] sel_addr;
  logic [DSIZE-1:0] sel_wdata;

  always_comb begin
    clearing  = rst_n && (state_q == StClear);
    running   = rst_n && (state_q == StRun);
    // Requester 1 wins when alone, or when both are valid and 0 was served last.
    grant1    = req1_valid && (!req0_valid || !last_grant_q);
    xfer      = running && (req0_valid || req1_valid);
    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;

    req0_ready = xfer && !grant1;
    req1_ready = xfer && grant1;
    busy       = clearing;

    if (clearing) begin
      ram_addra = clr_addr_q;
      ram_dinc  = '0;
      ram_wec   = 1'b1;
      ram_ena   = 1'b0;
    end else begin
      ram_addra = sel_addr;
      ram_dinc  = sel_wdata;
      ram_wec   = xfer && sel_we;
      ram_ena   = xfer && !sel_we;
    end

    rsp0_valid = rst_n && rd_pending_q && !rd_owner_q;
    rsp1_valid = rst_n && rd_pending_q && rd_owner_q;
    rsp0_rdata = rsp0_valid ? ram_douta : '0;
    rsp1_rdata = rsp1_valid ? ram_douta : '0;
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == StClear) begin
      clr_addr_d = clr_addr_q + ASIZE'(1);
      if (&clr_addr_q) begin
        state_d = StRun;
      end
    end
    last_grant_d = xfer ? grant1 : last_grant_q;
    rd_pending_d = xfer && !sel_we;
    rd_owner_d   = (xfer && !sel_we) ? grant1 : rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StRun;
      clr_addr_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (req1_ready && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expected read responses,
// a negedge monitor pops and compares them. Stats checks run when RAM_ARB_STATS_EN is defined.
module tb_ram_port_arbiter;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_we, req0_ready;
  logic [ASIZE-1:0] req0_addr;
  logic [DSIZE-1:0] req0_wdata;
  logic             req1_valid, req1_we, req1_ready;
  logic [ASIZE-1:0] req1_addr;
  logic [DSIZE-1:0] req1_wdata;
  logic             rsp0_valid, rsp1_valid;
  logic [DSIZE-1:0] rsp0_rdata, rsp1_rdata;
  logic [ASIZE-1:0] ram_addra;
  logic [DSIZE-1:0] ram_dinc, ram_douta;
  logic             ram_wec, ram_ena, busy;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]      grant0_cnt, grant1_cnt;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DSIZE          (DSIZE),
    .ASIZE          (ASIZE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_addra  (ram_addra),
    .ram_dinc   (ram_dinc),
    .ram_wec    (ram_wec),
    .ram_ena    (ram_ena),
    .ram_douta  (ram_douta),
    .busy       (busy)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
`endif
  );

  // Behavioural simple dual-port RAM, 1-cycle read latency.
  logic [DSIZE-1:0] mem [2**ASIZE];
  always @(posedge clk) begin
    if (ram_wec) mem[ram_addra] <= ram_dinc;
    if (ram_ena) ram_douta <= mem[ram_addra];
  end

  typedef struct packed {
    logic             owner;
    logic [DSIZE-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b, expected none",
                 rsp0_valid, rsp1_valid);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_both_valid", 32'(rsp0_valid && rsp1_valid), 32'd0);
        check("rsp_owner", 32'(rsp1_valid), 32'(e.owner));
        check("rsp_data", 32'(rsp1_valid ? rsp1_rdata : rsp0_rdata), 32'(e.data));
      end
    end
  end

  task automatic sweep_checks(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_wec"}, 32'(ram_wec), 32'd1);
      check({tag, "_addr"}, 32'(ram_addra), 32'(i));
      check({tag, "_dinc"}, 32'(ram_dinc), 32'd0);
      check({tag, "_ready0"}, 32'(req0_ready), 32'd0);
      step();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd5; req0_wdata = 8'hA5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd0; req1_wdata = 8'h00;
    step();
    step();

    // Reset: all combinational outputs forced low even with requests present.
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_wec", 32'(ram_wec), 32'd0);
    check("rst_ena", 32'(ram_ena), 32'd0);
    check("rst_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    step();

    // Clear sweep, with req0's write to addr 5 held pending throughout.
    rst_n      = 1'b1;
    req1_valid = 1'b0;
    sweep_checks("sweep1");
    @(negedge clk);
    check("run_busy", 32'(busy), 32'd0);
    check("run_ready0", 32'(req0_ready), 32'd1);
    check("wr_wec", 32'(ram_wec), 32'd1);
    check("wr_addr", 32'(ram_addra), 32'd5);
    check("wr_dinc", 32'(ram_dinc), 32'hA5);
    step();

    // Read-after-write from the other requester.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd5;
    exp_q.push_back('{owner: 1'b1, data: 8'hA5});
    @(negedge clk);
    check("raw_ready1", 32'(req1_ready), 32'd1);
    check("raw_ena", 32'(ram_ena), 32'd1);
    step();
    req1_we = 1'b1; req1_addr = 4'd3; req1_wdata = 8'h3C;
    @(negedge clk);
    check("raw_rsp1", 32'(rsp1_valid), 32'd1);
    check("raw_rsp0", 32'(rsp0_valid), 32'd0);
    step();

    // Contention: both read continuously, grants alternate starting at 0.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd3;
    for (int i = 0; i < 6; i++) begin
      logic g;
      g = 1'(i % 2);
      exp_q.push_back('{owner: g, data: g ? 8'h3C : 8'hA5});
      @(negedge clk);
      check("cont_ready0", 32'(req0_ready), 32'(!g));
      check("cont_ready1", 32'(req1_ready), 32'(g));
      step();
    end
    req0_valid = 1'b0;

    // Single requester: four consecutive writes from req1.
    req1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_addr  = 4'(8 + i);
      req1_wdata = 8'(8'h10 + i);
      @(negedge clk);
      check("solo_ready1", 32'(req1_ready), 32'd1);
      check("solo_wec", 32'(ram_wec), 32'd1);
      check("solo_addr", 32'(ram_addra), 32'(8 + i));
      step();
    end
    req1_valid = 1'b0;

    // Back-to-back readback by req0.
    req0_valid = 1'b1; req0_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 4'(8 + i);
      exp_q.push_back('{owner: 1'b0, data: 8'(8'h10 + i)});
      @(negedge clk);
      check("rb_ready0", 32'(req0_ready), 32'd1);
      step();
    end
    req0_valid = 1'b0;
    step();

    // Reset the cycle after a read is accepted: the response is dropped.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd8;
    @(negedge clk);
    check("mid_ready0", 32'(req0_ready), 32'd1);
    step();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_rsp0", 32'(rsp0_valid), 32'd0);
    check("mid_rsp1", 32'(rsp1_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    sweep_checks("sweep2");

    // First grant after reset goes to 0; RAM reads back zero after the sweep.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd8;
    exp_q.push_back('{owner: 1'b0, data: 8'h00});
    @(negedge clk);
    check("post_ready0", 32'(req0_ready), 32'd1);
    check("post_ready1", 32'(req1_ready), 32'd0);
    step();
    exp_q.push_back('{owner: 1'b1, data: 8'h00});
    @(negedge clk);
    check("post2_ready1", 32'(req1_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();

`ifdef RAM_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (16) step();
    req0_valid = 1'b1; req0_we = 1'b1;
    repeat (3) step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b1;
    repeat (2) step();
    req1_valid = 1'b0;
    @(negedge clk);
    check("cnt0", 32'(grant0_cnt), 32'd3);
    check("cnt1", 32'(grant1_cnt), 32'd2);
    step();
    req0_valid = 1'b1;
    repeat (65536) step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("cnt0_sat", 32'(grant0_cnt), 32'hFFFF);
    check("cnt1_hold", 32'(grant1_cnt), 32'd2);
    step();
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
